// File: rtl/flex_down_counter.sv
// Programmable down-counter with one-shot and periodic auto-reload modes.
// Optional prescaler dividing the count rate by 2^PRESCALE_BITS when FLEX_DOWN_PRESCALE_EN is defined.
module flex_down_counter #(
    parameter int NUM_BITS      = 4,
    parameter int PRESCALE_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_val,
    input  logic                count_enable,
    input  logic                periodic,
    output logic [NUM_BITS-1:0] count_out,
    output logic                busy,
    output logic                done,
    output logic                expire_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [NUM_BITS-1:0] count_reg, count_next;
    logic [NUM_BITS-1:0] reload_reg, reload_next;
    logic                expire_reg, expire_next;
    logic                busy_reg, done_reg;
    logic                tick;

`ifdef FLEX_DOWN_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] pre_reg, pre_next;

    // Prescaler advances only while running; a decrement happens on its wrap.
    assign tick = count_enable && (pre_reg == '1);

    always_comb begin
        pre_next = pre_reg;
        if (clear || load) begin
            pre_next = '0;
        end else if (state_reg == RUN && count_enable) begin
            pre_next = pre_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end
`else
    // No prescaler: every enabled cycle is a tick (width is always positive).
    assign tick = count_enable && (PRESCALE_BITS > 0);
`endif

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        expire_next = 1'b0;
        if (clear) begin
            state_next = IDLE;
            count_next = '0;
        end else if (load) begin
            count_next  = load_val;
            reload_next = load_val;
            state_next  = (load_val == '0) ? IDLE : RUN;
        end else if (state_reg == RUN && tick) begin
            if (count_reg > NUM_BITS'(1)) begin
                count_next = count_reg - NUM_BITS'(1);
            end else if (periodic) begin
                count_next  = reload_reg;
                expire_next = 1'b1;
            end else begin
                count_next  = '0;
                state_next  = EXPIRED;
                expire_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            reload_reg <= '0;
            expire_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            expire_reg <= expire_next;
            busy_reg   <= (state_next == RUN);
            done_reg   <= (state_next == EXPIRED);
        end
    end

    assign count_out    = count_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign expire_pulse = expire_reg;

endmodule

// File: tb/tb_flex_down_counter.sv
// Directed self-checking bench for flex_down_counter; inputs change 1 ns after
// each rising edge and outputs are checked at that same point.
module tb_flex_down_counter;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       count_enable = 1'b0;
    logic       periodic = 1'b0;
    logic [3:0] count_out;
    logic       busy;
    logic       done;
    logic       expire_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 tb_clk = ~tb_clk;

    flex_down_counter #(.NUM_BITS(4), .PRESCALE_BITS(2)) dut (
        .clk          (tb_clk),
        .rst          (rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .periodic     (periodic),
        .count_out    (count_out),
        .busy         (busy),
        .done         (done),
        .expire_pulse (expire_pulse)
    );

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] c, input logic b,
                         input logic d, input logic e);
        n_cmp++;
        assert ({count_out, busy, done, expire_pulse} === {c, b, d, e})
        else begin
            n_bad++;
            $error("FAIL %s: got count=%0d busy=%0b done=%0b exp=%0b, want count=%0d busy=%0b done=%0b exp=%0b",
                   tag, count_out, busy, done, expire_pulse, c, b, d, e);
        end
        $display("check %s: count=%0d busy=%0b done=%0b exp=%0b", tag, count_out, busy, done, expire_pulse);
    endtask

    initial begin
        logic [3:0] per_cnt [10];
        logic       per_exp [10];
        per_cnt = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};
        per_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset dominates a simultaneous load
        #1;
        rst = 1'b1; load = 1'b1; load_val = 4'd9;
        tick(); check("rst_cyc1", 4'd0, 0, 0, 0);
        tick(); check("rst_cyc2", 4'd0, 0, 0, 0);
        rst = 1'b0; load = 1'b0; load_val = 4'd0;
        tick(); check("post_rst_idle", 4'd0, 0, 0, 0);
        count_enable = 1'b1;
        tick(); check("idle_ignores_en", 4'd0, 0, 0, 0);
        count_enable = 1'b0;

`ifndef FLEX_DOWN_PRESCALE_EN
        // One-shot countdown from 5
        load = 1'b1; load_val = 4'd5; periodic = 1'b0;
        tick(); check("os_load", 4'd5, 1, 0, 0);
        load = 1'b0; count_enable = 1'b1;
        tick(); check("os_4", 4'd4, 1, 0, 0);
        tick(); check("os_3", 4'd3, 1, 0, 0);
        tick(); check("os_2", 4'd2, 1, 0, 0);
        tick(); check("os_1", 4'd1, 1, 0, 0);
        tick(); check("os_expire", 4'd0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            tick(); check($sformatf("os_hold%0d", i), 4'd0, 0, 1, 0);
        end

        // Periodic reload of 3
        count_enable = 1'b0; load = 1'b1; load_val = 4'd3; periodic = 1'b1;
        tick(); check("per_load", 4'd3, 1, 0, 0);
        load = 1'b0; count_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); check($sformatf("per_%0d", i), per_cnt[i], 1, 0, per_exp[i]);
        end

        // Enable gating and reload mid-run
        count_enable = 1'b0; load = 1'b1; load_val = 4'd7; periodic = 1'b0;
        tick(); check("gate_load", 4'd7, 1, 0, 0);
        load = 1'b0;
        count_enable = 1'b1; tick(); check("gate_en1", 4'd6, 1, 0, 0);
        count_enable = 1'b0; tick(); check("gate_en0", 4'd6, 1, 0, 0);
        count_enable = 1'b1; tick(); check("gate_en1b", 4'd5, 1, 0, 0);
        count_enable = 1'b0; tick(); check("gate_en0b", 4'd5, 1, 0, 0);
        count_enable = 1'b1; load = 1'b1; load_val = 4'd2;
        tick(); check("reload_mid_run", 4'd2, 1, 0, 0);
        load = 1'b0;
        tick(); check("reload_dec", 4'd1, 1, 0, 0);

        // Clear beats load
        count_enable = 1'b0; load = 1'b1; load_val = 4'd4;
        tick(); check("clr_setup", 4'd4, 1, 0, 0);
        clear = 1'b1; load = 1'b1; load_val = 4'd9;
        tick(); check("clr_over_load", 4'd0, 0, 0, 0);
        clear = 1'b0; load = 1'b0; count_enable = 1'b1;
        tick(); check("clr_idle", 4'd0, 0, 0, 0);

        // Load of zero parks in IDLE without expiry
        load = 1'b1; load_val = 4'd0;
        tick(); check("load_zero", 4'd0, 0, 0, 0);
        load = 1'b0;
        tick(); check("load_zero_hold", 4'd0, 0, 0, 0);
`else
        // Prescaled countdown: one decrement per 4 enabled cycles
        load = 1'b1; load_val = 4'd2; periodic = 1'b0;
        tick(); check("pre_load", 4'd2, 1, 0, 0);
        load = 1'b0; count_enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 4)       check($sformatf("pre_%0d", i), 4'd2, 1, 0, 0);
            else if (i < 8)  check($sformatf("pre_%0d", i), 4'd1, 1, 0, 0);
            else             check($sformatf("pre_%0d", i), 4'd0, 0, 1, 1);
        end
        tick(); check("pre_hold", 4'd0, 0, 1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
